// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Board-level self-check engine for a combinational LUT block. It steps
//   through every N_IN-bit input pattern and drives each one onto the block's
//   switch inputs. Each pattern is held for SETTLE_CYCLES+1 cycles. The LED
//   response is sampled in the last of those cycles and stored in a
//   LUT_INIT-ordered table: for output k, bit i holds the value for pattern i.
//
// Ports
//   i_Clk        clock, all logic on the rising edge
//   i_Rst        asynchronous active-high reset
//   i_Start      start a scan (only honoured in IDLE or DONE)
//   o_Busy       high while a scan is running
//   o_Done       one-cycle pulse when the table is complete
//   o_Valid      o_Table holds a complete scan
//   o_Pattern    pattern driven to the LUT block
//   i_Response   LUT block outputs (assumed synchronous to i_Clk)
//   o_Table      output k's truth table at [k*2^N_IN +: 2^N_IN]
//
// Optional build macro TT_SCAN_COMPARE_EN
//   Adds i_Expected, o_Match and o_Err_Count. Each sampled bit that differs
//   from the expected table increments o_Err_Count. o_Match is high when
//   o_Valid is high and no errors were counted. The scan itself behaves the
//   same with or without the macro.
//
// States
//   ST_IDLE   | waiting for the first start after reset
//   ST_DRIVE  | pattern held while the LUT block settles
//   ST_SAMPLE | response captured into the table
//   ST_DONE   | table complete; waiting for the next start

module truth_table_scanner #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic                          o_Valid,
  output logic [N_IN-1:0]               o_Pattern,
  input  logic [N_OUT-1:0]              i_Response,
  output logic [N_OUT*(2**N_IN)-1:0]    o_Table
`ifdef TT_SCAN_COMPARE_EN
  ,
  input  logic [N_OUT*(2**N_IN)-1:0]    i_Expected,
  output logic                          o_Match,
  output logic [N_IN+$clog2(N_OUT):0]   o_Err_Count
`endif
);

  localparam int DEPTH = 2**N_IN;
  localparam int TW    = N_OUT*DEPTH;
  localparam int SW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES+1) : 1;
  // The settle counter counts down. It is loaded with SETTLE_CYCLES-1, so
  // DRIVE lasts exactly SETTLE_CYCLES cycles before the terminal count.
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES-1 : 0);
  localparam logic [N_IN-1:0] LAST_PAT    = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // With no settle time, each new pattern is sampled in the cycle it appears.
  localparam state_e ST_FIRST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_DRIVE;

  state_e          state_q;
  logic [SW-1:0]   settle_q;
  logic [N_IN-1:0] pattern_q;
  logic            busy_q;
  logic            done_q;
  logic            valid_q;
  logic [TW-1:0]   table_q;

`ifdef TT_SCAN_COMPARE_EN
  localparam int EW = N_IN + $clog2(N_OUT) + 1;
  logic [EW-1:0] err_q;
  logic [EW-1:0] err_inc_d;

  // Number of outputs whose response disagrees with the expected table
  // at the current pattern.
  always_comb begin
    err_inc_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int p = 0; p < DEPTH; p++) begin
        if ((pattern_q == N_IN'(p)) && (i_Response[k] != i_Expected[k*DEPTH+p])) begin
          err_inc_d = err_inc_d + EW'(1);
        end
      end
    end
  end
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      table_q   <= '0;
`ifdef TT_SCAN_COMPARE_EN
      err_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_Start) begin
            pattern_q <= '0;
            settle_q  <= SETTLE_LOAD;
            valid_q   <= 1'b0;
            table_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_FIRST;
`ifdef TT_SCAN_COMPARE_EN
            err_q     <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          if (settle_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          // The loop uses constant indices, so no wide variable bit-select
          // is needed to write the table.
          for (int k = 0; k < N_OUT; k++) begin
            for (int p = 0; p < DEPTH; p++) begin
              if (pattern_q == N_IN'(p)) begin
                table_q[k*DEPTH+p] <= i_Response[k];
              end
            end
          end
`ifdef TT_SCAN_COMPARE_EN
          err_q <= err_q + err_inc_d;
`endif
          if (pattern_q == LAST_PAT) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pattern_q <= pattern_q + 1'b1;
            settle_q  <= SETTLE_LOAD;
            state_q   <= ST_FIRST;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Busy    = busy_q;
  assign o_Done    = done_q;
  assign o_Valid   = valid_q;
  assign o_Pattern = pattern_q;
  assign o_Table   = table_q;

`ifdef TT_SCAN_COMPARE_EN
  assign o_Err_Count = err_q;
  assign o_Match     = valid_q && (err_q == '0);
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner. Two instances share i_Start and i_Rst:
// dut_a uses SETTLE_CYCLES=2 and dut_b uses SETTLE_CYCLES=0. Each instance
// drives its own copy of the LUT model. The expected outputs come from a
// cycle-count model: the number of clock edges since the scan started
// determines the pattern, busy/valid/done, and which table bits are filled.
module tb_truth_table_scanner;

  localparam int SA    = 2;
  localparam int SB    = 0;
  localparam int DEPTH = 16;
  localparam logic [63:0] GOLDEN = 64'h8000_6996_FFF0_8888;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   lut_sel = 0;

  logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
  logic [3:0]  pat_a, pat_b, resp_a, resp_b;
  logic [63:0] tab_a, tab_b;
`ifdef TT_SCAN_COMPARE_EN
  logic [63:0] exp_vec = '0;
  logic        match_a, match_b;
  logic [6:0]  err_a, err_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // model state per instance
  int          mn[2];
  bit          mact[2];
  bit          mdone[2];
  logic [63:0] mtab[2] = '{default: '0};
  int          ms1, mL, mp;
  logic [3:0]  mr;

  always #5 clk = ~clk;

  function automatic logic [3:0] lut(input logic [3:0] p, input int sel);
    if (sel == 0) return {&p, ^p, p[2] | p[3], p[0] & p[1]};
    return (p * 4'd5) + 4'd3;
  endfunction

  always_comb resp_a = lut(pat_a, lut_sel);
  always_comb resp_b = lut(pat_b, lut_sel);

  truth_table_scanner #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(SA)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .o_Busy(busy_a), .o_Done(done_a), .o_Valid(valid_a),
    .o_Pattern(pat_a), .i_Response(resp_a), .o_Table(tab_a)
`ifdef TT_SCAN_COMPARE_EN
    , .i_Expected(exp_vec), .o_Match(match_a), .o_Err_Count(err_a)
`endif
  );

  truth_table_scanner #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(SB)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .o_Busy(busy_b), .o_Done(done_b), .o_Valid(valid_b),
    .o_Pattern(pat_b), .i_Response(resp_b), .o_Table(tab_b)
`ifdef TT_SCAN_COMPARE_EN
    , .i_Expected(exp_vec), .o_Match(match_b), .o_Err_Count(err_b)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a scan lasts 16*(S+1) edges after its start edge. Pattern p is
  // sampled on edge (S+1)*(p+1).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ms1 = ((i == 0) ? SA : SB) + 1;
      mL  = DEPTH * ms1;
      mdone[i] = 1'b0;
      if (rst) begin
        mact[i] = 1'b0; mn[i] = 0; mtab[i] = '0;
      end else if (start && !(mact[i] && mn[i] < mL)) begin
        mact[i] = 1'b1; mn[i] = 0; mtab[i] = '0;
      end else if (mact[i] && mn[i] < mL) begin
        mn[i]++;
        if (mn[i] % ms1 == 0) begin
          mp = mn[i] / ms1 - 1;
          mr = lut(4'(mp), lut_sel);
          for (int k = 0; k < 4; k++)
            if (mr[k]) mtab[i] = mtab[i] | (64'd1 << (k*DEPTH + mp));
        end
        if (mn[i] == mL) mdone[i] = 1'b1;
      end
    end
  end

  task automatic cmp(input int i, input logic busy, input logic done, input logic valid,
                     input logic [3:0] pat, input logic [63:0] tab);
    int s1, L, pe;
    s1 = ((i == 0) ? SA : SB) + 1;
    L  = DEPTH * s1;
    pe = mact[i] ? ((mn[i] / s1 > DEPTH-1) ? DEPTH-1 : mn[i] / s1) : 0;
    check($sformatf("busy[%0d]", i),    256'(busy),  256'(mact[i] && mn[i] < L));
    check($sformatf("done[%0d]", i),    256'(done),  256'(mdone[i]));
    check($sformatf("valid[%0d]", i),   256'(valid), 256'(mact[i] && mn[i] == L));
    check($sformatf("pattern[%0d]", i), 256'(pat),   256'(pe));
    check($sformatf("table[%0d]", i),   256'(tab),   256'(mtab[i]));
  endtask

  always @(negedge clk) begin
    cmp(0, busy_a, done_a, valid_a, pat_a, tab_a);
    cmp(1, busy_b, done_b, valid_b, pat_b, tab_b);
  end

  // Cycle c=1 is the first negedge after the start edge. The spec counts
  // latency from the cycle in which start is high, so done at c=49 means
  // 49 cycles.
  task automatic run_scan(input int hold, input int repulse_at, input int rst_at,
                          output int lat_a, output int lat_b, output int cnt_a, output int cnt_b);
    lat_a = -1; lat_b = -1; cnt_a = 0; cnt_b = 0;
    @(negedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk); #1;
      if (done_a) begin cnt_a++; if (lat_a < 0) lat_a = c; end
      if (done_b) begin cnt_b++; if (lat_b < 0) lat_b = c; end
      start = (c < hold) || (c == repulse_at);
      rst   = (c >= rst_at) && (c < rst_at + 2);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  int la, lb, ca, cb;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // reset / idle
    repeat (5) @(negedge clk);
    #1;
    check("idle_busy",  256'({busy_a, busy_b}),   256'(0));
    check("idle_done",  256'({done_a, done_b}),   256'(0));
    check("idle_valid", 256'({valid_a, valid_b}), 256'(0));
    check("idle_pat",   256'({pat_a, pat_b}),     256'(0));
    check("idle_table", 256'({tab_a, tab_b}),     256'(0));

    // basic scan, both settle settings
    run_scan(1, 0, 1000, la, lb, ca, cb);
    check("lat_s2", 256'(la), 256'(49));
    check("lat_s0", 256'(lb), 256'(17));
    check("pulses_s2", 256'(ca), 256'(1));
    check("pulses_s0", 256'(cb), 256'(1));
    check("golden_s2", 256'(tab_a), 256'(GOLDEN));
    check("golden_s0", 256'(tab_b), 256'(GOLDEN));
    check("valid_s2", 256'(valid_a), 256'(1));

    // start while busy is ignored
    run_scan(1, 10, 1000, la, lb, ca, cb);
    check("restart_lat", 256'(la), 256'(49));
    check("restart_pulses", 256'(ca), 256'(1));
    check("restart_table", 256'(tab_a), 256'(GOLDEN));

    // a different LUT function (model-checked every cycle)
    lut_sel = 1;
    run_scan(1, 0, 1000, la, lb, ca, cb);
    check("alt_lat_s2", 256'(la), 256'(49));
    check("alt_lat_s0", 256'(lb), 256'(17));
    lut_sel = 0;

    // start held high: back-to-back scans
    run_scan(60, 0, 1000, la, lb, ca, cb);
    check("held_lat_s2", 256'(la), 256'(49));
    check("held_pulses_s2", 256'(ca), 256'(2));
    check("held_pulses_s0", 256'(cb), 256'(4));

    // reset at cycle 20 aborts
    run_scan(1, 0, 20, la, lb, ca, cb);
    check("rst_no_done", 256'(ca), 256'(0));
    check("rst_table", 256'(tab_a), 256'(0));
    check("rst_valid", 256'(valid_a), 256'(0));
    run_scan(1, 0, 1000, la, lb, ca, cb);
    check("post_rst_lat", 256'(la), 256'(49));
    check("post_rst_table", 256'(tab_a), 256'(GOLDEN));

`ifdef TT_SCAN_COMPARE_EN
    exp_vec = GOLDEN ^ (64'd1 << 48);
    run_scan(1, 0, 1000, la, lb, ca, cb);
    check("err_one_s2", 256'(err_a), 256'(1));
    check("match_bad_s2", 256'(match_a), 256'(0));
    check("err_one_s0", 256'(err_b), 256'(1));
    exp_vec = GOLDEN;
    run_scan(1, 0, 1000, la, lb, ca, cb);
    check("err_zero_s2", 256'(err_a), 256'(0));
    check("match_good_s2", 256'(match_a), 256'(1));
    check("match_good_s0", 256'(match_b), 256'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
